// File: rtl/in32_dev.sv
// Bridge-attached 32-bit input port: synchronises and debounces din, latches
// selected edges into a write-1-to-clear pending register and raises a level irq.
module in32_dev #(
    parameter int WIDTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W = 16,
    parameter logic [DB_W-1:0] DB_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [1:0]       add_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             irq,
    input  logic [WIDTH-1:0] din
);

    // Bus handshake: we_i is a one-cycle store strobe that always completes on the
    // rising edge (no ready/backpressure); dat_o is a side-effect-free read of add_i.
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_DB   = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_prev;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [2:0]       ctrl;
    logic [2:0]       ctrl_next;
    logic [DB_W-1:0]  db;
    logic [DB_W-1:0]  cnt;
    logic [DB_W-1:0]  cnt_eff;
    logic             commit;
    logic             unused_dat;

    assign s = sync_q[SYNC_STAGES-1];
    assign unused_dat = ^dat_i;

    // The sample that first shows a new value already counts as one stable clock,
    // which is what makes a clean step land SYNC_STAGES + DB + 1 clocks later.
    always_comb begin
        cnt_eff   = (s == s_prev) ? cnt : '0;
        commit    = (s != stable) && (cnt_eff >= db);
        rise      = commit ? (~stable & s) : '0;
        fall      = commit ? (stable & ~s) : '0;
        ctrl_next = (we_i && add_i == ADDR_CTRL) ? dat_i[2:0] : ctrl;
        clr       = (we_i && add_i == ADDR_PEND) ? dat_i[WIDTH-1:0] : '0;
        // Set terms are ORed after the clear so a same-cycle edge wins.
        pend_next = (pend & ~clr)
                  | (ctrl[1] ? rise : '0)
                  | (ctrl[2] ? fall : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_prev <= '0;
            stable <= '0;
            cnt    <= '0;
            ctrl   <= '0;
            pend   <= '0;
            db     <= DB_RST;
            irq    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            s_prev <= s;
            ctrl   <= ctrl_next;
            pend   <= pend_next;
            irq    <= ctrl_next[0] & (|pend_next);
            if (we_i && add_i == ADDR_DB) begin
                db <= dat_i[DB_W-1:0];
            end
            if (s == stable) begin
                cnt <= '0;
            end else if (commit) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt_eff + DB_W'(1);
            end
        end
    end

    always_comb begin
        dat_o = '0;
        case (add_i)
            ADDR_DATA: dat_o[WIDTH-1:0] = stable;
            ADDR_CTRL: dat_o[2:0]       = ctrl;
            ADDR_PEND: dat_o[WIDTH-1:0] = pend;
            default:   dat_o[DB_W-1:0]  = db;
        endcase
    end

endmodule
